// File: rtl/mci_mcu_rst_req_ctrl.sv
// MCU reset request controller: turns a CSR request pulse into a held request and tracks sequencer ack/release.
// Optional acknowledge timeout is enabled by defining MCI_RST_REQ_TIMEOUT_EN.
module mci_mcu_rst_req_ctrl #(
  parameter int unsigned ACK_TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic mci_rst_b,
  input  logic rst_req_set,
  input  logic mcu_rst_b,
  input  logic fw_boot_upd_reset,
  input  logic fw_hitless_upd_reset,
  input  logic reason_boot_clr,
  input  logic reason_hitless_clr,
  output logic mcu_rst_req,
  output logic busy,
  output logic reason_boot_upd,
  output logic reason_hitless_upd,
  output logic done_pulse,
  output logic req_drop_err,
  output logic timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, IN_RST, DONE} state_e;

  state_e state_q, state_d;
  logic   mcu_rst_b_q;
  logic   ack, rel, tmo_hit;
  logic   req_d, latch_reason;

  if (ACK_TIMEOUT_WIDTH == 0) begin : g_width_check
    $error("ACK_TIMEOUT_WIDTH must be greater than zero");
  end

  // Edges rather than levels: the MCU may sit in reset before first boot.
  assign ack = mcu_rst_b_q & ~mcu_rst_b;
  assign rel = ~mcu_rst_b_q & mcu_rst_b;

`ifdef MCI_RST_REQ_TIMEOUT_EN
  localparam logic [ACK_TIMEOUT_WIDTH-1:0] CNT_ONE = ACK_TIMEOUT_WIDTH'(1);

  logic [ACK_TIMEOUT_WIDTH-1:0] ack_cnt_q;

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      ack_cnt_q <= '0;
    end else if (state_q == IDLE && rst_req_set) begin
      ack_cnt_q <= '0;
    end else if (state_q == REQ && ack_cnt_q != '1) begin
      ack_cnt_q <= ack_cnt_q + CNT_ONE;
    end
  end

  assign tmo_hit = (state_q == REQ) && !ack && (ack_cnt_q == '1);

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) timeout_err <= 1'b0;
    else            timeout_err <= tmo_hit;
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = mcu_rst_req;
    latch_reason = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_req_set) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          state_d      = IN_RST;
          req_d        = 1'b0;
          latch_reason = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      IN_RST: begin
        if (rel) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge mci_rst_b) begin
    if (!mci_rst_b) begin
      state_q            <= IDLE;
      mcu_rst_b_q        <= 1'b0;
      mcu_rst_req        <= 1'b0;
      done_pulse         <= 1'b0;
      req_drop_err       <= 1'b0;
      reason_boot_upd    <= 1'b0;
      reason_hitless_upd <= 1'b0;
    end else begin
      state_q      <= state_d;
      mcu_rst_b_q  <= mcu_rst_b;
      mcu_rst_req  <= req_d;
      done_pulse   <= (state_d == DONE);
      req_drop_err <= rst_req_set && (state_q != IDLE);
      // A reason being latched beats a W1C clear in the same cycle.
      if (latch_reason && fw_boot_upd_reset) reason_boot_upd <= 1'b1;
      else if (reason_boot_clr)              reason_boot_upd <= 1'b0;
      if (latch_reason && fw_hitless_upd_reset) reason_hitless_upd <= 1'b1;
      else if (reason_hitless_clr)              reason_hitless_upd <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
